// File: rtl/aibnd_red_clkmux_pkg.sv
// aibnd_red_clkmux_pkg -- shared types, select codes and helpers for the redundancy clock-mux controller.
// Rev 1.0
`default_nettype none

package aibnd_red_clkmux_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_GATE   = 3'd2,
        ST_SWITCH = 3'd3,
        ST_SETTLE = 3'd4
    } state_e;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_CLK1 = 2'd1;
    localparam logic [1:0] SEL_CLK2 = 2'd2;
    localparam logic [1:0] SEL_CLK3 = 2'd3;

    // Returns {s3,s2,s1}; an illegal code falls back to clk1 so the mux never sees 3'b000.
    function automatic logic [2:0] sel2onehot(input logic [1:0] sel);
        logic [2:0] oh;
        case (sel)
            SEL_CLK2: oh = 3'b010;
            SEL_CLK3: oh = 3'b100;
            default:  oh = 3'b001;
        endcase
        return oh;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aibnd_red_clkmux_ctl_if.sv
// aibnd_red_clkmux_ctl_if -- request/status bundle between a requester and the clock-mux sequencer.
// Rev 1.0
`default_nettype none

interface aibnd_red_clkmux_ctl_if;
    import aibnd_red_clkmux_pkg::*;

    logic       req_vld;
    logic [1:0] sel_req;
    logic       req_rdy;
    logic       done;
    logic       s1;
    logic       s2;
    logic       s3;
    logic       clk_en;
    logic [1:0] cur_sel;
    logic       busy;
    logic       err_illegal;
    logic       err_clr;

    modport master (
        output req_vld, sel_req, err_clr,
        input  req_rdy, done, s1, s2, s3, clk_en, cur_sel, busy, err_illegal
    );

    modport slave (
        input  req_vld, sel_req, err_clr,
        output req_rdy, done, s1, s2, s3, clk_en, cur_sel, busy, err_illegal
    );

endinterface

`default_nettype wire

// File: rtl/aibnd_red_dwell_cnt.sv
// aibnd_red_dwell_cnt -- loadable down-counter that saturates at zero and flags it.
// Rev 1.0
`default_nettype none

module aibnd_red_dwell_cnt #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= RST_VAL;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/aibnd_red_clkmux_ctl.sv
// aibnd_red_clkmux_ctl -- gate / switch / settle sequencer for the 3:1 redundancy clock mux selects.
// Rev 1.0
`default_nettype none

module aibnd_red_clkmux_ctl
    import aibnd_red_clkmux_pkg::*;
#(
    parameter int         GATE_CYC   = 4,
    parameter int         SETTLE_CYC = 8,
    parameter logic [1:0] DEF_SEL    = 2'd1
) (
    input  logic                          clk,
    input  logic                          reset,
    aibnd_red_clkmux_ctl_if.slave         ctl_if
);

    localparam int MAX_CYC = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] GATE_LD   = CW'(GATE_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
    localparam logic [2:0]    OH_RST    = sel2onehot(DEF_SEL);

    localparam logic [2:0] S_INIT   = 3'(ST_INIT);
    localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
    localparam logic [2:0] S_GATE   = 3'(ST_GATE);
    localparam logic [2:0] S_SWITCH = 3'(ST_SWITCH);
    localparam logic [2:0] S_SETTLE = 3'(ST_SETTLE);

    logic [2:0] state_q,  state_d;
    logic [1:0] sel_q,    sel_d;
    logic [2:0] onehot_q, onehot_d;
    logic [1:0] tgt_q,    tgt_d;
    logic       clk_en_q, clk_en_d;
    logic       rdy_q,    rdy_d;
    logic       busy_q,   busy_d;
    logic       done_q,   done_d;
    logic       err_q,    err_d;

    logic          cnt_load;
    logic [CW-1:0] cnt_val;
    logic          cnt_dec;
    logic          cnt_zero;
    logic          accept;

    aibnd_red_dwell_cnt #(
        .WIDTH   (CW),
        .RST_VAL (SETTLE_LD)
    ) u_dwell (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    assign accept = ctl_if.req_vld && rdy_q;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        onehot_d = onehot_q;
        tgt_d    = tgt_q;
        clk_en_d = clk_en_q;
        rdy_d    = rdy_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = ctl_if.err_clr ? 1'b0 : err_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;

        case (state_q)
            S_INIT: begin
                if (cnt_zero) begin
                    state_d  = S_IDLE;
                    clk_en_d = 1'b1;
                    rdy_d    = 1'b1;
                    busy_d   = 1'b0;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_IDLE: begin
                if (accept) begin
                    if (ctl_if.sel_req == SEL_NONE) begin
                        // An illegal accept overrides a simultaneous clear.
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else if (ctl_if.sel_req == sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        tgt_d    = ctl_if.sel_req;
                        state_d  = S_GATE;
                        clk_en_d = 1'b0;
                        rdy_d    = 1'b0;
                        busy_d   = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = GATE_LD;
                    end
                end
            end
            S_GATE: begin
                if (cnt_zero) begin
                    state_d  = S_SWITCH;
                    sel_d    = tgt_q;
                    onehot_d = sel2onehot(tgt_q);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_SWITCH: begin
                state_d  = S_SETTLE;
                cnt_load = 1'b1;
                cnt_val  = SETTLE_LD;
            end
            S_SETTLE: begin
                if (cnt_zero) begin
                    state_d  = S_IDLE;
                    clk_en_d = 1'b1;
                    rdy_d    = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                // Unreachable encodings re-run the post-reset settle with the clock gated.
                state_d  = S_INIT;
                clk_en_d = 1'b0;
                rdy_d    = 1'b0;
                busy_d   = 1'b1;
                cnt_load = 1'b1;
                cnt_val  = SETTLE_LD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_INIT;
            sel_q    <= DEF_SEL;
            onehot_q <= OH_RST;
            tgt_q    <= DEF_SEL;
            clk_en_q <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            onehot_q <= onehot_d;
            tgt_q    <= tgt_d;
            clk_en_q <= clk_en_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign ctl_if.s1          = onehot_q[0];
    assign ctl_if.s2          = onehot_q[1];
    assign ctl_if.s3          = onehot_q[2];
    assign ctl_if.cur_sel     = sel_q;
    assign ctl_if.clk_en      = clk_en_q;
    assign ctl_if.req_rdy     = rdy_q;
    assign ctl_if.busy        = busy_q;
    assign ctl_if.done        = done_q;
    assign ctl_if.err_illegal = err_q;

endmodule

`default_nettype wire

// File: tb/tb_aibnd_red_clkmux_ctl.sv
// tb_aibnd_red_clkmux_ctl -- directed and randomized checks against a timeline model of the sequencer.
// Rev 1.0
`default_nettype none

module tb_aibnd_red_clkmux_ctl;

    localparam int         G   = 4;
    localparam int         S   = 8;
    localparam logic [1:0] DEF = 2'd1;

    localparam int M_INIT = 0;
    localparam int M_IDLE = 1;
    localparam int M_SW   = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    aibnd_red_clkmux_ctl_if bus ();

    aibnd_red_clkmux_ctl #(
        .GATE_CYC   (G),
        .SETTLE_CYC (S),
        .DEF_SEL    (DEF)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .ctl_if (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: phase plus the cycle it began; every output is derived from elapsed cycles.
    int m_mode;
    int m_t0;
    int m_sel;
    int m_new;
    int m_done_at;
    bit m_err;
    bit m_acc;
    bit e_rdy;
    int bb;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [2:0] onehot_of(input int s);
        return 3'(1 << (s - 1));
    endfunction

    task automatic check_cycle();
        int n;
        int e_sel;
        n = cyc;
        if (m_mode == M_INIT && n >= m_t0 + S) m_mode = M_IDLE;
        if (m_mode == M_SW && n >= m_t0 + 2 + G + S) begin
            m_mode = M_IDLE;
            m_sel  = m_new;
        end
        e_rdy = (m_mode == M_IDLE);
        e_sel = (m_mode == M_SW && n >= m_t0 + 1 + G) ? m_new : m_sel;
        chk("req_rdy",     8'(bus.req_rdy),                8'(e_rdy));
        chk("clk_en",      8'(bus.clk_en),                 8'(e_rdy));
        chk("busy",        8'(bus.busy),                   8'(!e_rdy));
        chk("done",        8'(bus.done),                   8'(n == m_done_at));
        chk("err_illegal", 8'(bus.err_illegal),            8'(m_err));
        chk("cur_sel",     8'(bus.cur_sel),                8'(e_sel));
        chk("selects",     8'({bus.s3, bus.s2, bus.s1}),   8'(onehot_of(e_sel)));
    endtask

    task automatic step(input bit vld, input logic [1:0] sel, input bit clr, input bit rst_v);
        check_cycle();
        bus.req_vld = vld;
        bus.sel_req = sel;
        bus.err_clr = clr;
        if (rst_v && !reset) begin
            reset = 1'b1;
            #1;
            chk("async_selects", 8'({bus.s3, bus.s2, bus.s1}), 8'(onehot_of(int'(DEF))));
            chk("async_clk_en",  8'(bus.clk_en),               8'h00);
            chk("async_cur_sel", 8'(bus.cur_sel),              8'(DEF));
            chk("async_req_rdy", 8'(bus.req_rdy),              8'h00);
            chk("async_busy",    8'(bus.busy),                 8'h01);
        end else begin
            reset = rst_v;
        end
        @(posedge clk);
        m_acc = 1'b0;
        if (reset) begin
            m_mode    = M_INIT;
            m_t0      = cyc + 1;
            m_sel     = int'(DEF);
            m_err     = 1'b0;
            m_done_at = -1;
        end else begin
            m_acc = vld && e_rdy;
            if (m_acc && sel == 2'd0) m_err = 1'b1;
            else if (clr)             m_err = 1'b0;
            if (m_acc) begin
                if (sel == 2'd0 || int'(sel) == m_sel) begin
                    m_done_at = cyc + 1;
                end else begin
                    m_mode    = M_SW;
                    m_t0      = cyc;
                    m_new     = int'(sel);
                    m_done_at = cyc + 2 + G + S;
                end
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.req_vld = 1'b0;
        bus.sel_req = 2'd0;
        bus.err_clr = 1'b0;
        m_mode    = M_INIT;
        m_t0      = 0;
        m_sel     = int'(DEF);
        m_new     = int'(DEF);
        m_err     = 1'b0;
        m_done_at = -1;
        #1 reset = 1'b1;
        @(negedge clk);

        // Reset held, then released: clk_en and req_rdy rise SETTLE cycles later.
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b0, 1'b1);
        idle(12);

        // Same source, then a full switch to clk3.
        step(1'b1, 2'd1, 1'b0, 1'b0);
        idle(3);
        step(1'b1, 2'd3, 1'b0, 1'b0);
        idle(16);

        // Illegal code, clear colliding with a second illegal accept, then a lone clear.
        step(1'b1, 2'd0, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 2'd0, 1'b1, 1'b0);
        idle(1);
        step(1'b0, 2'd0, 1'b1, 1'b0);
        idle(2);

        // req_vld held high with alternating clk2/clk3 targets.
        bb = (m_sel == 2) ? 3 : 2;
        for (int i = 0; i < 60; i++) begin
            step(1'b1, 2'(bb), 1'b0, 1'b0);
            if (m_acc) bb = (bb == 2) ? 3 : 2;
        end
        idle(16);

        // Randomized requests, codes and clears.
        for (int i = 0; i < 80; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0), 1'b0);
        end
        idle(16);

        // Reset pulsed in the SETTLE phase of a switch to clk2.
        if (m_sel == 2) begin
            step(1'b1, 2'd1, 1'b0, 1'b0);
            idle(16);
        end
        step(1'b1, 2'd2, 1'b0, 1'b0);
        idle(G + 3);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b1);
        idle(14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
